// File: rtl/decoder_if.sv
// Digit/segment bundle between the timer logic and one 7-segment decoder.
// The master drives the digit code and controls; the slave returns segments.
interface decoder_if;
   logic       enable;
   logic       lamp_test;
   logic [3:0] binary_in;
   logic [6:0] decoder_out;
   logic       valid_out;

   modport master (
      output enable, lamp_test, binary_in,
      input  decoder_out, valid_out
   );

   modport slave (
      input  enable, lamp_test, binary_in,
      output decoder_out, valid_out
   );
endinterface

// File: rtl/decoder_unit.sv
// Registered BCD/hex to 7-segment decoder (bit6=a .. bit0=g), one-clock latency.
// Segment polarity is applied before the output register, so reset/blank/lamp follow it.
module decoder_unit #(
   parameter bit HEX_EN     = 1'b0,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic      clk,
   input  logic      rst,
   decoder_if.slave  bus
);

   localparam logic [6:0] POL       = {7{ACTIVE_LOW}};
   localparam logic [6:0] SEG_BLANK = 7'b000_0000 ^ POL;
   localparam logic [6:0] SEG_ALL   = 7'b111_1111 ^ POL;

   logic [6:0] dec_seg;
   logic       dec_valid;

   // NOTE: every output of a combinational block gets a default first, otherwise unlisted paths infer latches.
   always_comb begin
      dec_seg   = 7'b000_0000;
      dec_valid = 1'b1;
      case (bus.binary_in)
         4'h0: dec_seg = 7'b111_1110;
         4'h1: dec_seg = 7'b011_0000;
         4'h2: dec_seg = 7'b110_1101;
         4'h3: dec_seg = 7'b111_1001;
         4'h4: dec_seg = 7'b011_0011;
         4'h5: dec_seg = 7'b101_1011;
         4'h6: dec_seg = 7'b101_1111;
         4'h7: dec_seg = 7'b111_0000;
         4'h8: dec_seg = 7'b111_1111;
         4'h9: dec_seg = 7'b111_1011;
         4'hA: dec_seg = 7'b111_0111;
         4'hB: dec_seg = 7'b001_1111;
         4'hC: dec_seg = 7'b100_1110;
         4'hD: dec_seg = 7'b011_1101;
         4'hE: dec_seg = 7'b100_1111;
         4'hF: dec_seg = 7'b100_0111;
         default: begin
            dec_seg   = 7'b000_0000;
            dec_valid = 1'b0;
         end
      endcase
      // Letters are only displayable when hex mode is built in.
      if (!HEX_EN && (bus.binary_in > 4'd9)) begin
         dec_seg   = 7'b000_0000;
         dec_valid = 1'b0;
      end
   end

   // NOTE: registers are updated with non-blocking assignments so all flops sample pre-edge values together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.decoder_out <= SEG_BLANK;
         bus.valid_out   <= 1'b0;
      end else if (bus.lamp_test) begin
         bus.decoder_out <= SEG_ALL;
         bus.valid_out   <= 1'b0;
      end else if (bus.enable) begin
         bus.decoder_out <= dec_seg ^ POL;
         bus.valid_out   <= dec_valid;
      end
   end

endmodule

// File: tb/tb_decoder_unit.sv
// Scoreboard bench for decoder_unit: three builds (decimal, hex, decimal active-low)
// share one stimulus stream; a monitor compares each registered output against a queue.
module tb_decoder_unit;

   typedef struct {
      string      name;
      logic [6:0] seg_dec;
      logic       val_dec;
      logic [6:0] seg_hex;
      logic       val_hex;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   decoder_if if_dec ();
   decoder_if if_hex ();
   decoder_if if_al ();

   decoder_unit #(.HEX_EN(1'b0), .ACTIVE_LOW(1'b0)) u_dec (.clk(clk), .rst(rst), .bus(if_dec.slave));
   decoder_unit #(.HEX_EN(1'b1), .ACTIVE_LOW(1'b0)) u_hex (.clk(clk), .rst(rst), .bus(if_hex.slave));
   decoder_unit #(.HEX_EN(1'b0), .ACTIVE_LOW(1'b1)) u_al  (.clk(clk), .rst(rst), .bus(if_al.slave));

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got seg=%0d valid=%0b, expected seg=%0d valid=%0b",
                  name, act[6:0], act[7], exp[6:0], exp[7]);
      end
   endtask

   task automatic check_all(input string name, input exp_t e);
      check({name, "/dec"}, {if_dec.valid_out, if_dec.decoder_out}, {e.val_dec, e.seg_dec});
      check({name, "/hex"}, {if_hex.valid_out, if_hex.decoder_out}, {e.val_hex, e.seg_hex});
      check({name, "/al"},  {if_al.valid_out,  if_al.decoder_out},  {e.val_dec, ~e.seg_dec});
   endtask

   task automatic drive(input logic en, input logic lt, input logic [3:0] bin);
      if_dec.enable = en; if_dec.lamp_test = lt; if_dec.binary_in = bin;
      if_hex.enable = en; if_hex.lamp_test = lt; if_hex.binary_in = bin;
      if_al.enable  = en; if_al.lamp_test  = lt; if_al.binary_in  = bin;
   endtask

   // Drives one cycle of inputs and queues what the following edge must produce.
   task automatic step(input logic r, input logic en, input logic lt, input logic [3:0] bin,
                       input logic [6:0] s0, input logic v0, input logic [6:0] s1, input logic v1,
                       input string name);
      exp_t e;
      @(negedge clk);
      #1;
      rst = r;
      drive(en, lt, bin);
      e.name = name; e.seg_dec = s0; e.val_dec = v0; e.seg_hex = s1; e.val_hex = v1;
      sb_q.push_back(e);
   endtask

   // Monitor: outputs settle after the rising edge; compare on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_all(e.name, e);
         end
      end
   end

   logic [6:0] dec_tbl [10] = '{126, 48, 109, 121, 51, 91, 95, 112, 127, 123};
   logic [6:0] hex_tbl [6]  = '{119, 31, 78, 61, 79, 71};

   initial begin
      exp_t blank;
      blank.name = "reset"; blank.seg_dec = 7'd0; blank.val_dec = 1'b0;
      blank.seg_hex = 7'd0; blank.val_hex = 1'b0;
      drive(1'b0, 1'b0, 4'd0);
      #12;
      check_all("por", blank);

      // Decimal sweep; the first vector also releases reset with enable high.
      for (int i = 0; i < 10; i++)
         step(1'b0, 1'b1, 1'b0, 4'(i), dec_tbl[i], 1'b1, dec_tbl[i], 1'b1, $sformatf("dig%0d", i));
      for (int i = 0; i < 6; i++)
         step(1'b0, 1'b1, 1'b0, 4'(10 + i), 7'd0, 1'b0, hex_tbl[i], 1'b1, $sformatf("code%0d", 10 + i));

      // Enable hold.
      step(1'b0, 1'b1, 1'b0, 4'd5, 91, 1'b1, 91, 1'b1, "load5");
      for (int i = 0; i < 4; i++)
         step(1'b0, 1'b0, 1'b0, 4'd8, 91, 1'b1, 91, 1'b1, $sformatf("hold%0d", i));
      step(1'b0, 1'b1, 1'b0, 4'd8, 127, 1'b1, 127, 1'b1, "reload8");

      // Lamp test overrides a disabled load, then normal decoding resumes.
      step(1'b0, 1'b0, 1'b1, 4'd1, 127, 1'b0, 127, 1'b0, "lamp");
      step(1'b0, 1'b1, 1'b0, 4'd1, 48, 1'b1, 48, 1'b1, "lamp_rel");

      // Asynchronous reset between edges clears outputs at once.
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_all("async_rst", blank);
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b1, 1'b0, 4'd8, 7'd0, 1'b0, 7'd0, 1'b0, $sformatf("rst_hold%0d", i));
      step(1'b0, 1'b0, 1'b0, 4'd3, 7'd0, 1'b0, 7'd0, 1'b0, "rel_no_en");
      step(1'b0, 1'b1, 1'b0, 4'd3, 121, 1'b1, 121, 1'b1, "rel_load3");
      step(1'b0, 1'b1, 1'b1, 4'd0, 127, 1'b0, 127, 1'b0, "lamp_en");
      step(1'b0, 1'b1, 1'b0, 4'd0, 126, 1'b1, 126, 1'b1, "dig0_again");

      repeat (3) @(negedge clk);
      tests++;
      if (sb_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/decoder_unit.md
Name: decoder_unit

Overview:
- Registered BCD/hex to 7-segment decoder for the microwave display path.
- Takes a 4-bit digit from the timer/counter logic and drives one 7-segment digit.
- Segment output is registered, with a one-clock latency.
- Provides enable, lamp-test and digit-valid indication.

Parameters:
- HEX_EN, 0: 0 = codes 10..15 blank the display; 1 = codes 10..15 show A,b,C,d,E,F.
- ACTIVE_LOW, 0: 0 = segment lit by 1 (common cathode); 1 = all 7 segment bits inverted at the output register input (common anode), including reset and blank values.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous reset, active-high
- enable  input  1  1 = load the newly decoded value; 0 = hold outputs
- lamp_test  input  1  1 = force all segments lit
- binary_in  input  4  digit code to decode
- decoder_out  output  7  segment drive; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g
- valid_out  output  1  1 = registered digit was a legal displayable code

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset: decoder_out = blank (0000000; 1111111 when ACTIVE_LOW=1), valid_out = 0, effective immediately without a clock.
- Release of rst takes effect on the next rising clk edge.
- Decode table (ACTIVE_LOW=0, bit6..bit0):
  - 0 = 1111110 (126)
  - 1 = 0110000 (48)
  - 2 = 1101101 (109)
  - 3 = 1111001 (121)
  - 4 = 0110011 (51)
  - 5 = 1011011 (91)
  - 6 = 1011111 (95)
  - 7 = 1110000 (112)
  - 8 = 1111111 (127)
  - 9 = 1111011 (123)
- Codes 10..15 with HEX_EN=1:
  - A = 1110111 (119)
  - b = 0011111 (31)
  - C = 1001110 (78)
  - d = 0111101 (61)
  - E = 1001111 (79)
  - F = 1000111 (71)
  - valid_out = 1 for all six.
- Codes 10..15 with HEX_EN=0: decoder_out = blank 0000000, valid_out = 0.
- Codes 0..9: valid_out = 1.
- Priority at each rising clk edge, highest first:
  1. rst: asynchronous, overrides everything.
  2. lamp_test = 1: decoder_out = 1111111 (all lit; 0000000 if ACTIVE_LOW), valid_out = 0. Applies regardless of enable.
  3. enable = 1: register decode(binary_in) and its valid flag.
  4. enable = 0: hold both outputs unchanged.
- Latency: exactly 1 clk from sampling binary_in/enable/lamp_test to the outputs.
- Outputs change only on a clk edge or on rst assertion; no combinational path from inputs to outputs.
- X/Z on binary_in is not required to be handled. Synthesis is a full case with a blank default.
- Reset asserted mid-operation clears the outputs within the same cycle.
- On the first edge after reset release, a fresh value loads if enable = 1; otherwise the blank value is held.

Test Plan:
- Reset: assert rst asynchronously between edges -> decoder_out = 0, valid_out = 0 immediately. Hold 3 cycles; outputs stay 0.
- Decimal sweep: HEX_EN=0, enable=1, binary_in 0..9 one per cycle -> one cycle later decoder_out = 126, 48, 109, 121, 51, 91, 95, 112, 127, 123; valid_out = 1 throughout.
- Illegal codes: HEX_EN=0, binary_in 10..15 -> decoder_out = 0, valid_out = 0. Repeat with HEX_EN=1 -> 119, 31, 78, 61, 79, 71; valid_out = 1.
- Enable hold: load 5 (output 91), then enable=0 and binary_in=8 for 4 cycles -> output stays 91. Set enable=1 -> next edge gives 127.
- Lamp test priority: enable=0, binary_in=1, lamp_test=1 -> 127 with valid_out = 0. Release lamp_test with enable=1 -> 48 on the next edge.
- Polarity: ACTIVE_LOW=1, binary_in=0 -> decoder_out = 0000001 (1); reset value is 1111111 (127).
